axicb_write_scheduler: RTL and testbench

AXICB_WRITE_SCHEDULER -- requirements
Module: axicb_write_scheduler

---
 rtl/axicb_pkg.sv | 13 +
 rtl/axicb_round_robin_core.sv | 55 +++++
 rtl/axicb_write_scheduler.sv | 139 +++++++++++++
 tb/tb_axicb_write_scheduler.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
// rtl/axicb_pkg.sv - shared types and widths for the AXI crossbar write path
package axicb_pkg;

    localparam int AXI_LEN_W = 8;
    localparam int OSTD_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axicb_round_robin_core.sv
// rtl/axicb_round_robin_core.sv - mask-based round-robin arbiter with one-hot grant
module axicb_round_robin_core #(
    parameter int REQ_NB = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              en,
    input  logic [REQ_NB-1:0] req,
    output logic [REQ_NB-1:0] grant
);

    logic [REQ_NB-1:0] mask;
    logic [REQ_NB-1:0] mask_n;
    logic [REQ_NB-1:0] masked;
    logic              found;

    // Requesters above the last winner get first pick; fall back to the plain
    // lowest index once the masked set is exhausted.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        mask_n = mask;
        masked = req & mask;
        for (int i = 0; i < REQ_NB; i++) begin
            if (!found && masked[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                for (int j = 0; j < REQ_NB; j++) begin
                    mask_n[j] = (j > i);
                end
            end
        end
        for (int i = 0; i < REQ_NB; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                for (int j = 0; j < REQ_NB; j++) begin
                    mask_n[j] = (j > i);
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mask <= '1;
        end else if (srst) begin
            mask <= '1;
        end else if (en && (|req)) begin
            mask <= mask_n;
        end
    end

endmodule

// File: rtl/axicb_write_scheduler.sv
// rtl/axicb_write_scheduler.sv - AW/W ownership scheduler with outstanding-burst tracking
module axicb_write_scheduler
    import axicb_pkg::*;
#(
    parameter int REQ_NB   = 4,
    parameter int MAX_OSTD = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        srst,
    input  logic [REQ_NB-1:0]           req_valid,
    input  logic [REQ_NB*AXI_LEN_W-1:0] req_len,
    output logic [REQ_NB-1:0]           req_ready,
    output logic [REQ_NB-1:0]           sel,
    output logic                        slv_avalid,
    input  logic                        slv_aready,
    input  logic                        wbeat,
    output logic                        wlast,
    input  logic                        bdone,
    output logic                        busy,
    output logic                        ostd_full,
    output logic                        ostd_err
);

    localparam logic [OSTD_W-1:0] MAX_CNT = OSTD_W'(MAX_OSTD);

    wr_state_t             state;
    wr_state_t             state_n;
    logic [REQ_NB-1:0]     sel_n;
    logic [REQ_NB-1:0]     grant;
    logic [AXI_LEN_W-1:0]  beat_cnt;
    logic [AXI_LEN_W-1:0]  beat_n;
    logic [AXI_LEN_W-1:0]  grant_len;
    logic [OSTD_W-1:0]     ostd_cnt;
    logic [OSTD_W-1:0]     ostd_n;
    logic                  err_n;
    logic                  grant_en;
    logic                  aw_done;

    assign ostd_full = (ostd_cnt == MAX_CNT);
    assign busy      = (state != IDLE);
    assign grant_en  = (state == IDLE) && (|req_valid) && !ostd_full;
    assign aw_done   = (state == ADDR) && slv_aready;

    axicb_round_robin_core #(
        .REQ_NB (REQ_NB)
    ) u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .en      (grant_en),
        .req     (req_valid),
        .grant   (grant)
    );

    always_comb begin
        grant_len = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            if (grant[i]) begin
                grant_len = req_len[i*AXI_LEN_W +: AXI_LEN_W];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || srst) begin
            state    <= IDLE;
            sel      <= '0;
            beat_cnt <= '0;
            ostd_cnt <= '0;
            ostd_err <= 1'b0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            beat_cnt <= beat_n;
            ostd_cnt <= ostd_n;
            ostd_err <= err_n;
        end
    end

    // beat_cnt holds AWLEN, so the burst ends on the beat seen while it is zero.
    always_comb begin
        state_n    = state;
        sel_n      = sel;
        beat_n     = beat_cnt;
        slv_avalid = 1'b0;
        req_ready  = '0;
        wlast      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_en) begin
                    sel_n   = grant;
                    beat_n  = grant_len;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                slv_avalid = 1'b1;
                req_ready  = sel & {REQ_NB{slv_aready}};
                if (slv_aready) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                wlast = (beat_cnt == '0);
                if (wbeat) begin
                    if (beat_cnt == '0) begin
                        state_n = IDLE;
                        sel_n   = '0;
                    end else begin
                        beat_n = beat_cnt - AXI_LEN_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = '0;
            end
        endcase
    end

    // A simultaneous AW acceptance and B response cancel out.
    always_comb begin
        ostd_n = ostd_cnt;
        err_n  = ostd_err;
        if (aw_done && !bdone) begin
            if (ostd_cnt != MAX_CNT) begin
                ostd_n = ostd_cnt + OSTD_W'(1);
            end
        end else if (bdone && !aw_done) begin
            if (ostd_cnt != '0) begin
                ostd_n = ostd_cnt - OSTD_W'(1);
            end else begin
                err_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axicb_write_scheduler.sv
// tb/tb_axicb_write_scheduler.sv - randomized self-checking bench for axicb_write_scheduler
module tb_axicb_write_scheduler;

    localparam int N  = 4;
    localparam int MO = 2;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           srst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_len;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   sel;
    logic           slv_avalid;
    logic           slv_aready;
    logic           wbeat;
    logic           wlast;
    logic           bdone;
    logic           busy;
    logic           ostd_full;
    logic           ostd_err;

    int   vectors = 0;
    int   miscompares = 0;
    int   m_last;
    int   m_ostd;
    logic m_err;

    always #5 aclk = ~aclk;

    axicb_write_scheduler #(
        .REQ_NB   (N),
        .MAX_OSTD (MO)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .srst       (srst),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .sel        (sel),
        .slv_avalid (slv_avalid),
        .slv_aready (slv_aready),
        .wbeat      (wbeat),
        .wlast      (wlast),
        .bdone      (bdone),
        .busy       (busy),
        .ostd_full  (ostd_full),
        .ostd_err   (ostd_err)
    );

    // Next requester strictly after the previous winner, circularly.
    function automatic int pred_grant(logic [N-1:0] v);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k + N) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic quiet();
        req_valid  = '0;
        req_len    = '0;
        slv_aready = 1'b0;
        wbeat      = 1'b0;
        bdone      = 1'b0;
        srst       = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        quiet();
        req_valid = '1;
        cyc();
        cyc();
        #1;
        vectors++;
        if ({sel, req_ready, slv_avalid, wlast, busy, ostd_full, ostd_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got sel=%b rdy=%b av=%b wl=%b busy=%b full=%b err=%b want all 0",
                     sel, req_ready, slv_avalid, wlast, busy, ostd_full, ostd_err);
        end
        aresetn = 1'b1;
        req_valid = '0;
        m_last = -1;
        m_ostd = 0;
        m_err  = 1'b0;
        cyc();
    endtask

    task automatic test_round_robin();
        int g;
        logic [N-1:0] es;
        for (int i = 0; i < 5; i++) begin
            req_valid = '1; req_len = '0; slv_aready = 1'b1; wbeat = 1'b0; bdone = 1'b0;
            #1;
            g  = pred_grant(req_valid);
            es = onehot(g);
            vectors++;
            if (busy !== 1'b0 || sel !== '0) begin
                miscompares++;
                $display("FAIL rr_idle[%0d] got busy=%b sel=%b want 0 0", i, busy, sel);
            end
            cyc();
            #1;
            vectors++;
            if (sel !== es || slv_avalid !== 1'b1 || req_ready !== es) begin
                miscompares++;
                $display("FAIL rr_grant[%0d] got sel=%b av=%b rdy=%b want sel=%b av=1 rdy=%b",
                         i, sel, slv_avalid, req_ready, es, es);
            end
            m_last = g;
            m_ostd++;
            cyc();
            wbeat = 1'b1; bdone = 1'b1;
            m_ostd--;
            #1;
            vectors++;
            if (wlast !== 1'b1 || sel !== es) begin
                miscompares++;
                $display("FAIL rr_wlast[%0d] got wlast=%b sel=%b want 1 %b", i, wlast, sel, es);
            end
            cyc();
        end
        quiet();
    endtask

    task automatic test_aready_delay();
        int g;
        logic [N-1:0] es;
        req_valid = 4'b0100; req_len = 32'd3 << 16; slv_aready = 1'b0;
        #1;
        g  = pred_grant(req_valid);
        es = onehot(g);
        cyc();
        for (int d = 0; d < 5; d++) begin
            if (d == 2) req_valid = '0;
            #1;
            vectors++;
            if (slv_avalid !== 1'b1 || sel !== es || req_ready !== '0) begin
                miscompares++;
                $display("FAIL delay_hold[%0d] got av=%b sel=%b rdy=%b want 1 %b 0000",
                         d, slv_avalid, sel, req_ready, es);
            end
            cyc();
        end
        slv_aready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== es) begin
            miscompares++;
            $display("FAIL delay_ready got %b want %b", req_ready, es);
        end
        m_last = g;
        m_ostd++;
        cyc();
        slv_aready = 1'b0;
        req_valid  = '0;
        for (int b = 0; b < 4; b++) begin
            wbeat = 1'b1;
            #1;
            vectors++;
            if (wlast !== (b == 3) || sel !== es || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL delay_beat[%0d] got wlast=%b sel=%b busy=%b want %b %b 1",
                         b, wlast, sel, busy, (b == 3), es);
            end
            cyc();
        end
        wbeat = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || sel !== '0) begin
            miscompares++;
            $display("FAIL delay_done got busy=%b sel=%b want 0 0", busy, sel);
        end
        bdone = 1'b1;
        m_ostd--;
        cyc();
        bdone = 1'b0;
    endtask

    task automatic one_burst(input logic [N-1:0] v, input logic bd_in_addr, input string tag);
        int g;
        logic [N-1:0] es;
        req_valid = v; req_len = '0; slv_aready = 1'b1; bdone = 1'b0; wbeat = 1'b0;
        #1;
        g  = pred_grant(v);
        es = onehot(g);
        cyc();
        bdone = bd_in_addr;
        #1;
        vectors++;
        if (sel !== es || req_ready !== es) begin
            miscompares++;
            $display("FAIL %s_grant got sel=%b rdy=%b want %b", tag, sel, req_ready, es);
        end
        m_last = g;
        if (!bd_in_addr) m_ostd++;
        cyc();
        bdone = 1'b0; slv_aready = 1'b0; wbeat = 1'b1;
        cyc();
        wbeat = 1'b0;
    endtask

    task automatic test_ostd_full();
        int g3;
        one_burst('1, 1'b0, "full_b1");
        one_burst('1, 1'b0, "full_b2");
        req_valid = '1;
        #1;
        vectors++;
        if (ostd_full !== (m_ostd == MO)) begin
            miscompares++;
            $display("FAIL full_after2 got %b want %b", ostd_full, (m_ostd == MO));
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            vectors++;
            if (busy !== 1'b0 || sel !== '0) begin
                miscompares++;
                $display("FAIL full_nogrant[%0d] got busy=%b sel=%b want 0 0", c, busy, sel);
            end
        end
        g3 = pred_grant(req_valid);
        bdone = 1'b1;
        cyc();
        m_ostd--;
        bdone = 1'b0;
        #1;
        vectors++;
        if (ostd_full !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_release got full=%b busy=%b want 0 0", ostd_full, busy);
        end
        slv_aready = 1'b1;
        cyc();
        vectors++;
        if (sel !== onehot(g3) || slv_avalid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_third got sel=%b av=%b want %b 1", sel, slv_avalid, onehot(g3));
        end
        m_last = g3;
        m_ostd++;
        cyc();
        slv_aready = 1'b0; wbeat = 1'b1; req_valid = '0;
        cyc();
        wbeat = 1'b0;
        #1;
        vectors++;
        if (ostd_full !== (m_ostd == MO)) begin
            miscompares++;
            $display("FAIL full_again got %b want %b", ostd_full, (m_ostd == MO));
        end
        while (m_ostd > 0) begin
            bdone = 1'b1;
            cyc();
            m_ostd--;
        end
        bdone = 1'b0;
        #1;
        vectors++;
        if (ostd_full !== 1'b0 || ostd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain got full=%b err=%b want 0 0", ostd_full, ostd_err);
        end
    endtask

    task automatic test_simultaneous();
        one_burst(4'b1000, 1'b0, "sim_b1");
        one_burst(4'b1000, 1'b1, "sim_b2");
        #1;
        vectors++;
        if (ostd_full !== (m_ostd == MO)) begin
            miscompares++;
            $display("FAIL sim_count got full=%b want %b", ostd_full, (m_ostd == MO));
        end
        one_burst(4'b1000, 1'b0, "sim_b3");
        #1;
        vectors++;
        if (ostd_full !== (m_ostd == MO)) begin
            miscompares++;
            $display("FAIL sim_refill got full=%b want %b", ostd_full, (m_ostd == MO));
        end
        while (m_ostd > 0) begin
            bdone = 1'b1;
            cyc();
            m_ostd--;
        end
        bdone = 1'b0;
        #1;
        vectors++;
        if (ostd_err !== m_err) begin
            miscompares++;
            $display("FAIL sim_noerr got %b want %b", ostd_err, m_err);
        end
    endtask

    task automatic test_err();
        bdone = 1'b1;
        if (m_ostd == 0) m_err = 1'b1;
        cyc();
        bdone = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (ostd_err !== m_err) begin
                miscompares++;
                $display("FAIL err_sticky[%0d] got %b want %b", c, ostd_err, m_err);
            end
            cyc();
        end
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        m_err = 1'b0; m_last = -1; m_ostd = 0;
        vectors++;
        if (ostd_err !== 1'b0 || ostd_full !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear got err=%b full=%b want 0 0", ostd_err, ostd_full);
        end
    endtask

    task automatic test_srst_mid_burst();
        int g;
        req_valid = 4'b0010; req_len = 32'd7 << 8; slv_aready = 1'b1;
        #1;
        g = pred_grant(req_valid);
        cyc();
        m_last = g;
        m_ostd++;
        cyc();
        slv_aready = 1'b0; wbeat = 1'b1;
        cyc();
        cyc();
        wbeat = 1'b0; srst = 1'b1; req_valid = '1; req_len = '0;
        cyc();
        srst = 1'b0;
        m_last = -1; m_ostd = 0; m_err = 1'b0;
        #1;
        vectors++;
        if ({sel, req_ready, slv_avalid, wlast, busy, ostd_full, ostd_err} !== '0) begin
            miscompares++;
            $display("FAIL srst_outputs got sel=%b rdy=%b av=%b wl=%b busy=%b full=%b err=%b want all 0",
                     sel, req_ready, slv_avalid, wlast, busy, ostd_full, ostd_err);
        end
        g = pred_grant(req_valid);
        cyc();
        vectors++;
        if (sel !== onehot(g)) begin
            miscompares++;
            $display("FAIL srst_regrant got sel=%b want %b", sel, onehot(g));
        end
        m_last = g;
        slv_aready = 1'b1;
        m_ostd++;
        cyc();
        slv_aready = 1'b0; wbeat = 1'b1; req_valid = '0;
        cyc();
        wbeat = 1'b0; bdone = 1'b1;
        m_ostd--;
        cyc();
        bdone = 1'b0;
    endtask

    task automatic test_random();
        int lens[N];
        int g, d, beats, guard;
        logic granted, full_now, wb;
        logic [N-1:0] v, es;
        for (int it = 0; it < 30; it++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                lens[i] = (it == 7) ? 255 : int'($urandom_range(0, 4));
                req_len[i*8 +: 8] = 8'(lens[i]);
            end
            d = int'($urandom_range(0, 3));
            granted = 1'b0;
            guard = 0;
            g = -1;
            while (!granted && guard < 8) begin
                req_valid = v; slv_aready = 1'b0; wbeat = 1'b0;
                full_now = (m_ostd == MO);
                bdone = (m_ostd > 0) && (full_now || ($urandom_range(0, 1) == 1));
                #1;
                vectors++;
                if (ostd_full !== full_now || busy !== 1'b0 || ostd_err !== m_err) begin
                    miscompares++;
                    $display("FAIL rnd_idle[%0d] got full=%b busy=%b err=%b want %b 0 %b",
                             it, ostd_full, busy, ostd_err, full_now, m_err);
                end
                granted = !full_now;
                if (granted) g = pred_grant(v);
                cyc();
                if (bdone) m_ostd--;
                bdone = 1'b0;
                guard++;
            end
            es = onehot(g);
            for (int c = 0; c <= d; c++) begin
                slv_aready = (c == d);
                #1;
                vectors++;
                if (slv_avalid !== 1'b1 || sel !== es || req_ready !== ((c == d) ? es : '0)) begin
                    miscompares++;
                    $display("FAIL rnd_addr[%0d] got av=%b sel=%b rdy=%b want 1 %b",
                             it, slv_avalid, sel, req_ready, es);
                end
                cyc();
            end
            m_last = g;
            m_ostd++;
            slv_aready = 1'b0;
            beats = (g >= 0) ? lens[g] + 1 : 1;
            guard = 0;
            while (beats > 0 && guard < 2000) begin
                wb = ($urandom_range(0, 3) != 0);
                wbeat = wb;
                if ($urandom_range(0, 3) == 0) req_valid = '0;
                #1;
                vectors++;
                if (wlast !== (beats == 1) || sel !== es) begin
                    miscompares++;
                    $display("FAIL rnd_data[%0d] got wlast=%b sel=%b want %b %b",
                             it, wlast, sel, (beats == 1), es);
                end
                cyc();
                if (wb) beats--;
                guard++;
            end
            wbeat = 1'b0;
            #1;
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_end[%0d] got busy=%b want 0", it, busy);
            end
        end
        req_valid = '0;
        while (m_ostd > 0) begin
            bdone = 1'b1;
            cyc();
            m_ostd--;
        end
        bdone = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0;
        quiet();
        cyc();
        test_reset();
        test_round_robin();
        test_aready_delay();
        test_ostd_full();
        test_simultaneous();
        test_err();
        test_srst_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
